// File: rtl/tick_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tick_pkg
// Description : Shared types and constants for the tick scheduler: the FSM
//               state encoding, default timing parameters, the common
//               counter width and the state transition function.
// Revision    : 1.0 - initial release
// ============================================================================
package tick_pkg;

    // Counter / terminal register width; wide enough for CLK_HZ at 100 MHz
    // and for the slowest game period (16 * GAME_BASE).
    localparam int c_CNT_W = 28;

    // Default timing for the 100 MHz board build.
    localparam int c_DEF_CLK_HZ    = 100_000_000;
    localparam int c_DEF_PIX_DIV   = 4;
    localparam int c_DEF_GAME_BASE = 1_000_000;
    localparam int c_DEF_BLINK_DIV = 25_000_000;

    // Seconds display range 0..59.
    localparam logic [5:0] c_SEC_LAST = 6'd59;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSE  = 2'd2,
        RELOAD = 2'd3
    } tick_state_t;

    // Next state of the run/pause/reload sequencer. A speed load wins over a
    // run change in the same cycle; a load seen in IDLE is serviced without
    // leaving IDLE, and a load seen in RELOAD is dropped.
    function automatic tick_state_t next_state(
        input tick_state_t cur,
        input logic        run,
        input logic        speed_load
    );
        tick_state_t nxt;
        nxt = cur;
        case (cur)
            IDLE:   nxt = speed_load ? IDLE : (run ? RUN : IDLE);
            RUN:    nxt = speed_load ? RELOAD : (run ? RUN : PAUSE);
            PAUSE:  nxt = speed_load ? RELOAD : (run ? RUN : PAUSE);
            RELOAD: nxt = run ? RUN : PAUSE;
            default: nxt = IDLE;
        endcase
        return nxt;
    endfunction

endpackage : tick_pkg
`default_nettype wire

// File: rtl/strobe_counter.sv
`default_nettype none
// ============================================================================
// Module      : strobe_counter
// Description : Modulus counter producing a registered one-cycle strobe.
//               Each enabled cycle advances the count; the enabled cycle that
//               finds the count at period-1 wraps it to 0 and raises strobe
//               for the following cycle.
// Ports       : clk    - system clock
//               clr    - synchronous active-high reset
//               en     - count enable for this cycle
//               load   - synchronous clear of count and strobe
//               period - modulus in clk-enable cycles (must be >= 1)
//               strobe - registered one-cycle terminal strobe
// Revision    : 1.0 - initial release
// ============================================================================
module strobe_counter
    import tick_pkg::*;
#(
    parameter int WIDTH = c_CNT_W
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] period,
    output logic             strobe
);

    logic [WIDTH-1:0] r_count;
    logic             r_strobe;
    logic             w_terminal;

    // ">=" rather than "==" so a counter never runs away past a shortened
    // period; in normal use the period only changes together with a clear.
    assign w_terminal = (r_count >= (period - WIDTH'(1)));

    always_ff @(posedge clk) begin
        if (clr || load) begin
            r_count  <= '0;
            r_strobe <= 1'b0;
        end else if (en) begin
            if (w_terminal) begin
                r_count  <= '0;
                r_strobe <= 1'b1;
            end else begin
                r_count  <= r_count + WIDTH'(1);
                r_strobe <= 1'b0;
            end
        end else begin
            r_strobe <= 1'b0;
        end
    end

    assign strobe = r_strobe;

endmodule : strobe_counter
`default_nettype wire

// File: rtl/tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tick_scheduler
// Description : Single-clock timing controller. Produces one-cycle clock
//               enables (pixel, game tick, blink, seconds) on the system
//               clock, a 0..59 seconds counter, run/pause sequencing and a
//               load/ack handshake for changing the game speed on the fly.
// Ports       : clk        - system clock, rising edge
//               clr        - synchronous active-high reset
//               run        - 1 = game time advances, 0 = paused
//               speed_val  - game-speed selector, sampled on speed_load
//               speed_load - one-cycle request to apply speed_val
//               speed_ack  - one-cycle pulse when the new speed is in effect
//               pix_en     - free-running strobe every PIX_DIV cycles
//               game_en    - game-tick strobe, period (speed+1)*GAME_BASE
//               blink_en   - strobe every BLINK_DIV RUN cycles
//               sec_en     - strobe every CLK_HZ RUN cycles
//               sec_count  - seconds elapsed, 0..59, wraps
//               state      - IDLE=0, RUN=1, PAUSE=2, RELOAD=3
// Revision    : 1.0 - initial release
// ============================================================================
module tick_scheduler
    import tick_pkg::*;
#(
    parameter int CLK_HZ    = c_DEF_CLK_HZ,
    parameter int PIX_DIV   = c_DEF_PIX_DIV,
    parameter int GAME_BASE = c_DEF_GAME_BASE,
    parameter int BLINK_DIV = c_DEF_BLINK_DIV
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       run,
    input  logic [3:0] speed_val,
    input  logic       speed_load,
    output logic       speed_ack,
    output logic       pix_en,
    output logic       game_en,
    output logic       blink_en,
    output logic       sec_en,
    output logic [5:0] sec_count,
    output logic [1:0] state
);

    localparam logic [c_CNT_W-1:0] c_PIX_PERIOD   = c_CNT_W'(PIX_DIV);
    localparam logic [c_CNT_W-1:0] c_BLINK_PERIOD = c_CNT_W'(BLINK_DIV);
    localparam logic [c_CNT_W-1:0] c_SEC_PERIOD   = c_CNT_W'(CLK_HZ);
    localparam logic [c_CNT_W-1:0] c_GAME_BASE    = c_CNT_W'(GAME_BASE);

    tick_state_t        r_state;
    tick_state_t        w_state_nxt;
    logic               r_speed_ack;
    logic [5:0]         r_sec_count;
    logic [c_CNT_W-1:0] r_game_period;
    logic [c_CNT_W-1:0] w_game_period_new;
    logic               w_accept_load;
    logic               w_count_en;
    logic               w_game_clear;
    logic               w_sec_en;

    always_comb begin
        w_state_nxt = next_state(r_state, run, speed_load);
    end

    // Time counters advance on every edge that lands in a RUN cycle, so each
    // strobe is raised in the very RUN cycle that completes its period and
    // never appears while the block is paused, idle or reloading.
    assign w_count_en   = (w_state_nxt == RUN);

    // The game counter is zeroed on entry to RELOAD; the first RUN cycle
    // afterwards is therefore cycle 1 of a fresh period.
    assign w_game_clear = (w_state_nxt == RELOAD);

    // Loads are honoured in IDLE, RUN and PAUSE; a load during RELOAD is lost.
    assign w_accept_load = speed_load && (r_state != RELOAD);

    // Terminal value of the game counter for the requested speed. The latched
    // speed lives only in this register: the reset value GAME_BASE is the
    // speed-0 period.
    assign w_game_period_new = (c_CNT_W'(speed_val) + c_CNT_W'(1)) * c_GAME_BASE;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state       <= IDLE;
            r_speed_ack   <= 1'b0;
            r_sec_count   <= '0;
            r_game_period <= c_GAME_BASE;
        end else begin
            r_state     <= w_state_nxt;
            // Ack follows the RELOAD cycle; an IDLE load is acknowledged on
            // the next cycle since no RELOAD cycle is taken there.
            r_speed_ack <= (r_state == RELOAD) ||
                           ((r_state == IDLE) && speed_load);
            if (w_accept_load) begin
                r_game_period <= w_game_period_new;
            end
            if (w_sec_en) begin
                r_sec_count <= (r_sec_count == c_SEC_LAST) ? 6'd0
                                                           : r_sec_count + 6'd1;
            end
        end
    end

    strobe_counter #(
        .WIDTH (c_CNT_W)
    ) u_pix_cnt (
        .clk    (clk),
        .clr    (clr),
        .en     (1'b1),
        .load   (1'b0),
        .period (c_PIX_PERIOD),
        .strobe (pix_en)
    );

    strobe_counter #(
        .WIDTH (c_CNT_W)
    ) u_game_cnt (
        .clk    (clk),
        .clr    (clr),
        .en     (w_count_en),
        .load   (w_game_clear),
        .period (r_game_period),
        .strobe (game_en)
    );

    strobe_counter #(
        .WIDTH (c_CNT_W)
    ) u_blink_cnt (
        .clk    (clk),
        .clr    (clr),
        .en     (w_count_en),
        .load   (1'b0),
        .period (c_BLINK_PERIOD),
        .strobe (blink_en)
    );

    strobe_counter #(
        .WIDTH (c_CNT_W)
    ) u_sec_cnt (
        .clk    (clk),
        .clr    (clr),
        .en     (w_count_en),
        .load   (1'b0),
        .period (c_SEC_PERIOD),
        .strobe (w_sec_en)
    );

    assign sec_en    = w_sec_en;
    assign speed_ack = r_speed_ack;
    assign sec_count = r_sec_count;
    assign state     = r_state;

endmodule : tick_scheduler
`default_nettype wire

// File: tb/tb_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_tick_scheduler
// Description : Self-checking bench for tick_scheduler, small-parameter build.
//               A cycle-level reference model counts elapsed cycles and RUN
//               cycles and derives every strobe from modular arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_scheduler;

    localparam int CLK_HZ    = 20;
    localparam int PIX_DIV   = 4;
    localparam int GAME_BASE = 5;
    localparam int BLINK_DIV = 10;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       run = 1'b0;
    logic [3:0] speed_val = 4'd0;
    logic       speed_load = 1'b0;
    logic       speed_ack;
    logic       pix_en;
    logic       game_en;
    logic       blink_en;
    logic       sec_en;
    logic [5:0] sec_count;
    logic [1:0] state;

    tick_scheduler #(
        .CLK_HZ    (CLK_HZ),
        .PIX_DIV   (PIX_DIV),
        .GAME_BASE (GAME_BASE),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .run        (run),
        .speed_val  (speed_val),
        .speed_load (speed_load),
        .speed_ack  (speed_ack),
        .pix_en     (pix_en),
        .game_en    (game_en),
        .blink_en   (blink_en),
        .sec_en     (sec_en),
        .sec_count  (sec_count),
        .state      (state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: 0=IDLE 1=RUN 2=PAUSE 3=RELOAD
    int m_state;
    int m_cycles;      // cycles since clr released
    int m_game_runs;   // RUN cycles since clr or last reload
    int m_runs;        // RUN cycles since clr
    int m_speed;
    int m_sec_fired;   // seconds strobes so far
    bit e_pix, e_game, e_blink, e_sec, e_ack;
    int e_sec_count;
    bit saw59, saw_wrap;

    function automatic int model_next(input int cur, input bit r, input bit ld);
        if (cur == 3) return r ? 1 : 2;
        if (cur == 0) return ld ? 0 : (r ? 1 : 0);
        return ld ? 3 : (r ? 1 : 2);
    endfunction

    // One clock: drive inputs on the falling edge, predict, check after rise.
    task automatic step(input bit c, input bit r, input bit ld, input int v);
        int nxt;
        @(negedge clk);
        clr        = c;
        run        = r;
        speed_load = ld;
        speed_val  = 4'(v);
        if (c) begin
            m_state = 0; m_cycles = 0; m_game_runs = 0; m_runs = 0;
            m_speed = 0; m_sec_fired = 0; e_sec_count = 0;
            e_pix = 0; e_game = 0; e_blink = 0; e_sec = 0; e_ack = 0;
        end else begin
            if (e_sec) m_sec_fired++;
            e_sec_count = m_sec_fired % 60;
            e_ack = (m_state == 3) || (m_state == 0 && ld);
            if (ld && m_state != 3) m_speed = v;
            nxt = model_next(m_state, r, ld);
            m_cycles++;
            e_pix = (m_cycles % PIX_DIV) == 0;
            if (nxt == 3) m_game_runs = 0;
            if (nxt == 1) begin
                m_game_runs++;
                m_runs++;
                e_game  = (m_game_runs % ((m_speed + 1) * GAME_BASE)) == 0;
                e_blink = (m_runs % BLINK_DIV) == 0;
                e_sec   = (m_runs % CLK_HZ) == 0;
            end else begin
                e_game = 0; e_blink = 0; e_sec = 0;
            end
            m_state = nxt;
        end
        @(posedge clk);
        #1;
        check("state",     32'(state),     32'(m_state));
        check("pix_en",    32'(pix_en),    32'(e_pix));
        check("game_en",   32'(game_en),   32'(e_game));
        check("blink_en",  32'(blink_en),  32'(e_blink));
        check("sec_en",    32'(sec_en),    32'(e_sec));
        check("speed_ack", 32'(speed_ack), 32'(e_ack));
        check("sec_count", 32'(sec_count), 32'(e_sec_count));
        if (sec_count == 6'd59) saw59 = 1'b1;
        if (saw59 && sec_count == 6'd0) saw_wrap = 1'b1;
    endtask

    initial begin
        bit r_lvl;
        saw59 = 0; saw_wrap = 0;

        // Reset, then idle with run low: only pix_en moves.
        repeat (2) step(1, 0, 0, 0);
        repeat (40) step(0, 0, 0, 0);

        // Run long enough for the seconds counter to wrap.
        repeat (1230) step(0, 1, 0, 0);
        check("sec59_seen", 32'(saw59), 32'd1);
        check("sec_wrap_seen", 32'(saw_wrap), 32'd1);

        // Pause three RUN cycles into a game period, resume.
        for (int i = 0; i < 10 && (m_game_runs % GAME_BASE) != 3; i++) step(0, 1, 0, 0);
        check("pause_phase", 32'(m_game_runs % GAME_BASE), 32'd3);
        repeat (50) step(0, 0, 0, 0);
        repeat (12) step(0, 1, 0, 0);

        // Speed change in RUN; a second load during RELOAD is dropped.
        step(0, 1, 1, 3);
        step(0, 1, 1, 7);
        repeat (70) step(0, 1, 0, 0);

        // Speed change while paused and while idle.
        step(0, 0, 0, 0);
        step(0, 0, 1, 1);
        repeat (5) step(0, 0, 0, 0);
        repeat (30) step(0, 1, 0, 0);

        // Clear mid-run with sec_count at 7.
        for (int i = 0; i < 400 && !(m_state == 1 && e_sec_count == 7); i++) step(0, 1, 0, 0);
        check("sec_count_at_7", 32'(sec_count), 32'd7);
        step(1, 1, 0, 0);
        step(0, 0, 1, 2);
        repeat (3) step(0, 0, 0, 0);
        repeat (20) step(0, 1, 0, 0);

        // Randomised traffic.
        r_lvl = 1;
        for (int i = 0; i < 4000; i++) begin
            bit c, ld;
            if ($urandom_range(0, 19) == 0) r_lvl = ~r_lvl;
            ld = ($urandom_range(0, 24) == 0);
            c  = ($urandom_range(0, 699) == 0);
            step(c, r_lvl, ld, int'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_tick_scheduler
`default_nettype wire

// File: doc/tick_scheduler.md
# tick_scheduler

Single-clock timing controller for the lab4 VGA game. It replaces the free-running divided clocks with one-cycle clock-enable strobes on the system clock: a pixel enable, a game-tick enable with a programmable rate, a blink enable and a seconds enable, plus a 0–59 seconds counter. It sits between the board clock and the VGA, game-logic and display blocks. It adds run/pause sequencing and a handshake for changing the game speed on the fly.

## Interface
- CLK_HZ, 100_000_000, system clock cycles per second; period of sec_en
- PIX_DIV, 4, period of pix_en in clk cycles (25 MHz pixel rate)
- GAME_BASE, 1_000_000, base game-tick period; game period = (speed+1)*GAME_BASE
- BLINK_DIV, 25_000_000, period of blink_en in clk cycles
- clk  in  1  system clock, 100 MHz, all logic on rising edge
- clr  in  1  synchronous active-high reset
- run  in  1  level; 1 = game time advances, 0 = paused
- speed_val  in  4  requested game-speed selector, sampled on speed_load
- speed_load  in  1  one-cycle request to apply speed_val
- speed_ack  out  1  one-cycle pulse when the new speed is in effect
- pix_en  out  1  one-cycle strobe every PIX_DIV cycles; free-running
- game_en  out  1  one-cycle game-tick strobe; only in RUN
- blink_en  out  1  one-cycle strobe every BLINK_DIV cycles; only in RUN
- sec_en  out  1  one-cycle strobe every CLK_HZ cycles; only in RUN
- sec_count  out  6  seconds elapsed, 0..59, wraps
- state  out  2  FSM state: IDLE=0, RUN=1, PAUSE=2, RELOAD=3

## Operation
- All outputs are registered. The reset values are: state=IDLE, all strobes 0, speed_ack 0, sec_count 0, latched speed 0, and all counters 0.
- Pixel counter:
  - Runs in every state except during clr.
  - Counts 0..PIX_DIV-1 and raises pix_en for the cycle after the count reaches PIX_DIV-1.
- Game, blink and seconds counters:
  - Advance only in RUN.
  - Hold their value in PAUSE and IDLE, so resuming continues the partial period exactly.
  - Are not cleared by pause.
- sec_count:
  - Increments when sec_en fires and wraps 59 -> 0.
  - Has 6-bit width; never shows a value above 59.
- FSM transitions:
  - IDLE -> RUN when run=1.
  - RUN -> PAUSE when run=0.
  - PAUSE -> RUN when run=1.
  - RUN or PAUSE -> RELOAD when speed_load=1. speed_load has priority over a run change in the same cycle.
  - RELOAD lasts exactly one cycle. In it, speed_val is latched, the game counter is cleared and speed_ack is asserted. Next state is RUN if run=1, else PAUSE.
  - IDLE with speed_load: latch speed_val and pulse speed_ack the next cycle. Stay in IDLE; no RELOAD state.
- speed_load while in RELOAD is ignored. No ack is given; the requester must re-issue.
- Blink and seconds counters are not affected by RELOAD. They do not advance during the RELOAD cycle.
- Game period arithmetic is (latched_speed+1)*GAME_BASE, computed at load time into a 28-bit terminal register. speed 0 gives the fastest tick (GAME_BASE), speed 15 the slowest (16*GAME_BASE).
- Only clr returns the block to IDLE. A clr asserted mid-period discards all partial counts.

## Timing
- pix_en:
  - The first pulse is in cycle PIX_DIV after clr deasserts (cycles counted from 1).
  - After that it pulses every PIX_DIV cycles, exactly one cycle wide.
- In RUN, game_en fires after game-period cycles spent in RUN; blink_en and sec_en do the same for their own periods. Cycles in PAUSE, IDLE or RELOAD do not count.
- speed_ack is high in the cycle after the RELOAD cycle, i.e. 2 cycles after speed_load is sampled. In IDLE it is 1 cycle after.
- After RELOAD, the first game_en is a full new period counted from the first RUN cycle.
- Strobes from different counters may coincide in the same cycle. There is no arbitration.
- The run→state change takes effect on the next edge, with one cycle of latency.

## Structure
- Package tick_pkg holds:
  - the state enum (IDLE, RUN, PAUSE, RELOAD);
  - the default values of CLK_HZ, PIX_DIV, GAME_BASE and BLINK_DIV;
  - the 28-bit counter width constant.
- Sub-module strobe_counter:
  - Ports: clk, clr, en, load (clear), period input, strobe output.
  - Modulus counter with a one-cycle terminal strobe.
  - Instantiated four times: pixel, game, blink and seconds.
- The FSM, speed latch and sec_count live in tick_scheduler.

## Test plan
All scenarios use the small-parameter build CLK_HZ=20, PIX_DIV=4, GAME_BASE=5, BLINK_DIV=10.
- Reset, then run=0 for 40 cycles -> pix_en pulses at cycles 4, 8, 12…; game_en, blink_en and sec_en stay 0; state stays IDLE.
- run=1, speed 0 -> state=RUN next cycle; game_en every 5 cycles, blink_en every 10, sec_en every 20.
- Run 1200 cycles -> sec_count reaches 59, then wraps to 0 on the 60th sec_en.
- run=0 after 3 RUN cycles of a game period, hold 50 cycles, then run=1 -> no strobes during PAUSE; game_en arrives exactly 2 RUN cycles after resume.
- In RUN, speed_val=3 with speed_load:
  - state=RELOAD for one cycle, then speed_ack 2 cycles after the load;
  - game_en every 20 cycles afterwards;
  - a second speed_load during RELOAD is ignored.
- clr asserted mid-run with sec_count=7 -> next cycle all outputs are at their reset values and state=IDLE.
